series_host: RTL and testbench
==============================

# series_host

Request-side sequencer for the series accelerator controller/datapath pair. It takes one user command (term count `n` and a double-width operand `x`) over a valid/ready port and drives the accelerator's `start` line and shared narrow input bus through the load sequence: start, n, x low, x high, release. It then waits for the accelerator to return to its ready/idle state, captures the result, and presents it on a valid/ready response port. A watchdog aborts the wait if the accelerator hangs.

## Interface
- `W`, 8: accelerator input-bus width; `n` width.
- `RW`, 16: accelerator result width.
- `TIMEOUT`, 1023: maximum cycles spent in WAIT_DONE before abort. Must be at least 1.
- `clk`  in  1  single clock. All logic is rising-edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  1  command present.
- `req_ready`  out  1  block can accept a command.
- `req_n`  in  W  term count.
- `req_x`  in  2W  operand. Sent as two W-bit halves.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  response consumed.
- `rsp_result`  out  RW  captured accelerator result. 0 on timeout.
- `rsp_timeout`  out  1  response is an abort.
- `acc_start`  out  1  accelerator start request.
- `acc_bus`  out  W  accelerator data bus.
- `acc_ready`  in  1  accelerator idle/ready. High means the accelerator is idle and `acc_result` is final.
- `acc_result`  in  RW  accelerator result register.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States and actions:
  - **IDLE**: `req_ready = !rsp_valid`. On `req_valid && req_ready`, latch `n` and `x`, then go to START.
  - **START**: `acc_start = acc_ready`. If `acc_ready`, go to SEND_N; otherwise stay, with `acc_start = 0`. This state waits out a still-busy accelerator, for example after reset or a timeout.
  - **SEND_N**: `acc_start = 1`, `acc_bus = n`. Go to SEND_XL.
  - **SEND_XL**: `acc_start = 1`, `acc_bus = x[W-1:0]`. Go to SEND_XH.
  - **SEND_XH**: `acc_start = 1`, `acc_bus = x[2W-1:W]`. Go to RELEASE.
  - **RELEASE**: `acc_start = 0`. This is the accelerator's init cycle. Go to WAIT_DONE and clear the watchdog.
  - **WAIT_DONE**: watchdog increments each cycle.
    - If `acc_ready`, capture `rsp_result = acc_result`, set `rsp_timeout = 0` and `rsp_valid = 1`, then go to IDLE.
    - Else if watchdog equals `TIMEOUT - 1`, set `rsp_result = 0`, `rsp_timeout = 1` and `rsp_valid = 1`, then go to IDLE.
- SEND_N, SEND_XL and SEND_XH line up one-for-one with the accelerator's load-n, load-x-low and load-x-high cycles. They must be contiguous and cannot stall.
- `acc_bus = 0` in every state other than SEND_N, SEND_XL and SEND_XH.
- Response register:
  - `rsp_valid` stays set until the cycle in which `rsp_valid && rsp_ready`, then clears.
  - `rsp_result` and `rsp_timeout` are stable while `rsp_valid` is high.
  - While `rsp_valid` is high, `req_ready = 0`, so one response is outstanding at most.
- Protocol check: if `acc_ready = 1` during SEND_N, the handshake was lost. The FSM continues unchanged. Benches flag this as an error via assertion.
- Watchdog: `$clog2(TIMEOUT+1)` bits wide, saturating. It counts only in WAIT_DONE.

## Timing
- Reset (synchronous):
  - State goes to IDLE.
  - `acc_start = 0`, `acc_bus = 0`, `rsp_valid = 0`, `rsp_result = 0`, `rsp_timeout = 0`, `busy = 0`, `req_ready = 1`.
  - Latched `n`, `x` and the watchdog clear to 0.
- Reset mid-sequence:
  - `acc_start` drops on the edge where `rst` is sampled.
  - Any pending response is discarded.
  - The next command waits in START until `acc_ready` is high.
- `acc_start` and `acc_bus` are decoded combinationally from state and latched data. `acc_start` in START additionally depends on `acc_ready`. All other outputs are registered.
- Latency, with accept at edge E0 and the accelerator already ready:
  - START at cycle 1, where `acc_start` goes high.
  - SEND_N at cycle 2, SEND_XL at cycle 3, SEND_XH at cycle 4.
  - RELEASE at cycle 5.
  - WAIT_DONE from cycle 6.
  - `rsp_valid` rises on the edge after the first WAIT_DONE cycle that sees `acc_ready = 1`.
- Back-to-back commands: `rsp_ready = 1` together with `req_valid = 1` in the cycle `rsp_valid` clears lets the next accept happen the cycle after. This gives at least 7 cycles per command plus compute time.
- Simultaneous `acc_ready` and watchdog terminal count in WAIT_DONE: the normal completion wins (`rsp_timeout = 0`).

## Test plan
- **Single command**: W=8. Command `n = 3`, `x = 0x1234`. Behavioural accelerator returns 0xBEEF 6 cycles after init.
  - Bus reads 0x03, 0x34, 0x12 on cycles 2, 3, 4.
  - `acc_start` is high on cycles 1-4 and low on cycle 5.
  - `rsp_valid` rises with `rsp_result = 0xBEEF` and `rsp_timeout = 0`.
- **Busy accelerator at accept**: hold `acc_ready = 0` for 10 cycles after accept.
  - The block stays in START with `acc_start = 0`.
  - SEND_N follows exactly one cycle after `acc_ready` rises.
- **Timeout**: TIMEOUT=8. Accelerator never re-asserts ready.
  - `rsp_valid` rises with `rsp_result = 0` and `rsp_timeout = 1` after 8 WAIT_DONE cycles.
  - The next command blocks in START.
- **Response backpressure**: hold `rsp_ready = 0` for 20 cycles.
  - `rsp_result` and `rsp_timeout` stay stable and `req_ready` stays 0 throughout.
  - Release, then issue a second command `n = 0`, `x = 0xFFFF`. It completes with the correct bus bytes 0x00, 0xFF, 0xFF.
- **Reset in SEND_XL**: assert `rst` for 1 cycle while in SEND_XL.
  - `acc_start` and `acc_bus` read 0 on the next cycle.
  - All outputs match their reset values and `req_ready = 1`.
- **Tie case**: `acc_ready` rises in the same cycle the watchdog hits `TIMEOUT - 1`.
  - Response is `rsp_timeout = 0` with the real `acc_result`.

Source files
------------

// File: rtl/series_host.sv
// series_host: sequences one command into the series accelerator (start, n, x low, x high, release),
// waits for completion under a watchdog and holds the result on a valid/ready response port.
module series_host #(
  parameter int W = 8,
  parameter int RW = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [W-1:0]   req_n,
  input  logic [2*W-1:0] req_x,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [RW-1:0]  rsp_result,
  output logic           rsp_timeout,
  output logic           acc_start,
  output logic [W-1:0]   acc_bus,
  input  logic           acc_ready,
  input  logic [RW-1:0]  acc_result,
  output logic           busy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, START, SEND_N, SEND_XL, SEND_XH, RELEASE, WAIT_DONE} state_t;
  state_t state, state_nx;
  logic [W-1:0] n_q;
  logic [2*W-1:0] x_q;
  logic [CW-1:0] wd;
  logic done, expire;
  assign req_ready = state == IDLE && !rsp_valid;
  assign busy = state != IDLE;
  // completion takes priority over the watchdog terminal count
  assign done = state == WAIT_DONE && acc_ready;
  assign expire = state == WAIT_DONE && !acc_ready && wd == CW'(TIMEOUT - 1);
  always_comb begin
    state_nx = state;
    acc_start = 1'b0;
    acc_bus = '0;
    case (state)
      IDLE: state_nx = req_valid && req_ready ? START : IDLE;
      START: begin
        acc_start = acc_ready;
        state_nx = acc_ready ? SEND_N : START;
      end
      SEND_N: begin
        acc_start = 1'b1;
        acc_bus = n_q;
        state_nx = SEND_XL;
      end
      SEND_XL: begin
        acc_start = 1'b1;
        acc_bus = x_q[W-1:0];
        state_nx = SEND_XH;
      end
      SEND_XH: begin
        acc_start = 1'b1;
        acc_bus = x_q[2*W-1:W];
        state_nx = RELEASE;
      end
      RELEASE: state_nx = WAIT_DONE;
      WAIT_DONE: state_nx = done || expire ? IDLE : WAIT_DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n_q <= '0;
      x_q <= '0;
      wd <= '0;
      rsp_valid <= 1'b0;
      rsp_result <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      if (req_valid && req_ready) begin
        n_q <= req_n;
        x_q <= req_x;
      end
      if (state == RELEASE) wd <= '0;
      else if (state == WAIT_DONE && wd != '1) wd <= wd + CW'(1);
      if (done || expire) begin
        rsp_valid <= 1'b1;
        rsp_result <= done ? acc_result : '0;
        rsp_timeout <= !done;
      end else if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_series_host.sv
// tb_series_host: directed scenarios for series_host with the accelerator driven cycle by cycle.
module tb_series_host;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [7:0] req_n = '0;
  logic [15:0] req_x = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic rsp_timeout;
  logic acc_start;
  logic [7:0] acc_bus;
  logic acc_ready = 1'b1;
  logic [15:0] acc_result = '0;
  logic busy;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  series_host #(.W(8), .RW(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n), .req_x(req_x),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
    .acc_start(acc_start), .acc_bus(acc_bus), .acc_ready(acc_ready), .acc_result(acc_result),
    .busy(busy)
  );
  // a ready accelerator during SEND_N means the start handshake was lost
  always @(negedge clk)
    if (!rst) assert (!(dut.state == 3'd2 && acc_ready)) else $error("FAIL proto acc_ready high in SEND_N");
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic accept(input logic [7:0] n, input logic [15:0] x);
    req_valid = 1'b1;
    req_n = n;
    req_x = x;
    cyc();
    req_valid = 1'b0;
  endtask
  task automatic drain;
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    checks++;
    if ({acc_start, acc_bus, rsp_valid, rsp_result, rsp_timeout, busy, req_ready} !==
        {1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset got start=%b bus=%h v=%b res=%h to=%b busy=%b rdy=%b exp 0 00 0 0000 0 0 1",
               acc_start, acc_bus, rsp_valid, rsp_result, rsp_timeout, busy, req_ready);
    end
    cyc();
    rst = 1'b0;
  endtask
  task automatic test_single;
    logic [7:0] bus_exp [5];
    bus_exp = '{8'h00, 8'h03, 8'h34, 8'h12, 8'h00};
    acc_ready = 1'b1;
    accept(8'd3, 16'h1234);
    for (int c = 1; c <= 12; c++) begin
      acc_ready = c == 1 || c >= 11;
      acc_result = c >= 11 ? 16'hBEEF : 16'h0000;
      @(negedge clk);
      if (c <= 5) begin
        checks++;
        if (acc_start !== (c <= 4)) begin errors++; $display("FAIL single_start c=%0d got %b", c, acc_start); end
        checks++;
        if (acc_bus !== bus_exp[c-1]) begin errors++; $display("FAIL single_bus c=%0d got %h exp %h", c, acc_bus, bus_exp[c-1]); end
      end
      checks++;
      if (rsp_valid !== (c == 12)) begin errors++; $display("FAIL single_valid c=%0d got %b", c, rsp_valid); end
      if (c == 12) begin
        checks++;
        if ({rsp_result, rsp_timeout, req_ready} !== {16'hBEEF, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL single_rsp got res=%h to=%b rdy=%b exp beef 0 0", rsp_result, rsp_timeout, req_ready);
        end
      end
      cyc();
    end
    drain();
    @(negedge clk);
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL single_drain got v=%b rdy=%b exp 0 1", rsp_valid, req_ready); end
    cyc();
  endtask
  task automatic test_busy;
    logic [7:0] bus_exp [5];
    bus_exp = '{8'h00, 8'h05, 8'h5A, 8'hA5, 8'h00};
    acc_ready = 1'b0;
    accept(8'd5, 16'hA55A);
    for (int c = 1; c <= 18; c++) begin
      acc_ready = c == 11 || c >= 17;
      acc_result = c >= 17 ? 16'h1357 : 16'h0000;
      @(negedge clk);
      if (c <= 10) begin
        checks++;
        if ({acc_start, acc_bus, busy} !== {1'b0, 8'h00, 1'b1}) begin
          errors++;
          $display("FAIL busy_hold c=%0d got start=%b bus=%h busy=%b exp 0 00 1", c, acc_start, acc_bus, busy);
        end
      end else if (c <= 15) begin
        checks++;
        if ({acc_start, acc_bus} !== {c <= 14, bus_exp[c-11]}) begin
          errors++;
          $display("FAIL busy_seq c=%0d got start=%b bus=%h exp %b %h", c, acc_start, acc_bus, c <= 14, bus_exp[c-11]);
        end
      end
      checks++;
      if (rsp_valid !== (c == 18)) begin errors++; $display("FAIL busy_valid c=%0d got %b", c, rsp_valid); end
      if (c == 18) begin
        checks++;
        if ({rsp_result, rsp_timeout} !== {16'h1357, 1'b0}) begin errors++; $display("FAIL busy_rsp got %h %b exp 1357 0", rsp_result, rsp_timeout); end
      end
      cyc();
    end
    drain();
  endtask
  task automatic test_timeout;
    acc_ready = 1'b1;
    acc_result = 16'hDEAD;
    accept(8'd9, 16'h0102);
    for (int c = 1; c <= 14; c++) begin
      acc_ready = c == 1;
      @(negedge clk);
      checks++;
      if (rsp_valid !== (c == 14)) begin errors++; $display("FAIL timeout_valid c=%0d got %b", c, rsp_valid); end
      if (c == 14) begin
        checks++;
        if ({rsp_result, rsp_timeout} !== {16'h0000, 1'b1}) begin errors++; $display("FAIL timeout_rsp got %h %b exp 0000 1", rsp_result, rsp_timeout); end
      end
      cyc();
    end
    drain();
    accept(8'd1, 16'h0001);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if ({acc_start, acc_bus, busy} !== {1'b0, 8'h00, 1'b1}) begin
        errors++;
        $display("FAIL timeout_block c=%0d got start=%b bus=%h busy=%b exp 0 00 1", c, acc_start, acc_bus, busy);
      end
      cyc();
    end
    acc_ready = 1'b1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask
  task automatic test_backpressure;
    logic [7:0] bus_exp [5];
    bus_exp = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00};
    acc_ready = 1'b1;
    accept(8'h02, 16'h0F0F);
    for (int c = 1; c <= 7; c++) begin
      acc_ready = c == 1 || c == 7;
      acc_result = c == 7 ? 16'h0C0C : 16'h0000;
      cyc();
    end
    acc_result = 16'h9999;
    req_valid = 1'b1;
    req_n = 8'h00;
    req_x = 16'hFFFF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_result, rsp_timeout, req_ready, busy} !== {1'b1, 16'h0C0C, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold i=%0d got v=%b res=%h to=%b rdy=%b busy=%b exp 1 0c0c 0 0 0",
                 i, rsp_valid, rsp_result, rsp_timeout, req_ready, busy);
      end
      cyc();
    end
    drain();
    @(negedge clk);
    checks++;
    if ({rsp_valid, req_ready, busy} !== 3'b010) begin errors++; $display("FAIL bp_release got v=%b rdy=%b busy=%b exp 0 1 0", rsp_valid, req_ready, busy); end
    cyc();
    req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      acc_ready = c == 1 || c == 7;
      acc_result = c == 7 ? 16'h00AA : 16'h0000;
      @(negedge clk);
      if (c <= 5) begin
        checks++;
        if ({acc_start, acc_bus} !== {c <= 4, bus_exp[c-1]}) begin
          errors++;
          $display("FAIL bp_seq c=%0d got start=%b bus=%h exp %b %h", c, acc_start, acc_bus, c <= 4, bus_exp[c-1]);
        end
      end
      checks++;
      if (rsp_valid !== (c == 8)) begin errors++; $display("FAIL bp_valid c=%0d got %b", c, rsp_valid); end
      if (c == 8) begin
        checks++;
        if ({rsp_result, rsp_timeout} !== {16'h00AA, 1'b0}) begin errors++; $display("FAIL bp_rsp got %h %b exp 00aa 0", rsp_result, rsp_timeout); end
      end
      cyc();
    end
    drain();
  endtask
  task automatic test_tie;
    acc_ready = 1'b1;
    accept(8'd4, 16'h5678);
    for (int c = 1; c <= 14; c++) begin
      acc_ready = c == 1 || c == 13;
      acc_result = c == 13 ? 16'h4242 : 16'h0000;
      @(negedge clk);
      checks++;
      if (rsp_valid !== (c == 14)) begin errors++; $display("FAIL tie_valid c=%0d got %b", c, rsp_valid); end
      if (c == 14) begin
        checks++;
        if ({rsp_result, rsp_timeout} !== {16'h4242, 1'b0}) begin errors++; $display("FAIL tie_rsp got %h %b exp 4242 0", rsp_result, rsp_timeout); end
      end
      cyc();
    end
    drain();
  endtask
  task automatic test_reset_mid;
    acc_ready = 1'b1;
    accept(8'd7, 16'hC3A5);
    cyc();
    acc_ready = 1'b0;
    cyc();
    @(negedge clk);
    checks++;
    if ({acc_start, acc_bus} !== {1'b1, 8'hA5}) begin errors++; $display("FAIL rstmid_xl got start=%b bus=%h exp 1 a5", acc_start, acc_bus); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({acc_start, acc_bus, rsp_valid, rsp_result, rsp_timeout, busy, req_ready} !==
        {1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rstmid got start=%b bus=%h v=%b res=%h to=%b busy=%b rdy=%b exp 0 00 0 0000 0 0 1",
               acc_start, acc_bus, rsp_valid, rsp_result, rsp_timeout, busy, req_ready);
    end
    cyc();
    accept(8'd1, 16'h0001);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if ({acc_start, busy} !== 2'b01) begin errors++; $display("FAIL rstmid_block c=%0d got start=%b busy=%b exp 0 1", c, acc_start, busy); end
      cyc();
    end
    acc_ready = 1'b1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask
  initial begin
    test_reset();
    test_single();
    test_busy();
    test_timeout();
    test_backpressure();
    test_tie();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
